// File: rtl/unsigned_16bit_alu_if.sv
// Operand/opcode/result bundle between the execution sequencer and the 16-bit ALU.
interface unsigned_16bit_alu_if;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        Arith_Flag;
    logic        Logic_Flag;
    logic        CMP_Flag;
    logic        Shift_Flag;

    modport master (
        output A, B, ALU_FUN,
        input  ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
    );

    modport slave (
        input  A, B, ALU_FUN,
        output ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag
    );
endinterface

// File: rtl/unsigned_16bit_alu.sv
// Registered 16-bit unsigned ALU: one-cycle arithmetic/logic/compare/shift with a
// one-hot operation-class flag set captured alongside the result.
module unsigned_16bit_alu (
    input  logic                   CLK,
    input  logic                   RST,
    unsigned_16bit_alu_if.slave    bus
);
    // Class flags packed as {arith, logic, cmp, shift}
    localparam logic [3:0] FLG_NONE  = 4'b0000;
    localparam logic [3:0] FLG_ARITH = 4'b1000;
    localparam logic [3:0] FLG_LOGIC = 4'b0100;
    localparam logic [3:0] FLG_CMP   = 4'b0010;
    localparam logic [3:0] FLG_SHIFT = 4'b0001;

    logic [15:0] res_d;
    logic [15:0] res_q;
    logic [3:0]  flg_d;
    logic [3:0]  flg_q;

    // Result and flag selection from the current opcode and operands
    always_comb begin
        res_d = 16'h0000;
        flg_d = FLG_NONE;
        case (bus.ALU_FUN)
            4'b0000: begin res_d = bus.A + bus.B; flg_d = FLG_ARITH; end
            4'b0001: begin res_d = bus.A - bus.B; flg_d = FLG_ARITH; end
            4'b0010: begin res_d = bus.A * bus.B; flg_d = FLG_ARITH; end
            4'b0011: begin
                // Divide-by-zero yields zero rather than an undefined quotient
                if (bus.B == 16'h0000) begin
                    res_d = 16'h0000;
                end else begin
                    res_d = bus.A / bus.B;
                end
                flg_d = FLG_ARITH;
            end
            4'b0100: begin res_d = bus.A & bus.B;    flg_d = FLG_LOGIC; end
            4'b0101: begin res_d = bus.A | bus.B;    flg_d = FLG_LOGIC; end
            4'b0110: begin res_d = ~(bus.A & bus.B); flg_d = FLG_LOGIC; end
            4'b0111: begin res_d = ~(bus.A | bus.B); flg_d = FLG_LOGIC; end
            4'b1000: begin res_d = bus.A ^ bus.B;    flg_d = FLG_LOGIC; end
            4'b1001: begin res_d = ~(bus.A ^ bus.B); flg_d = FLG_LOGIC; end
            4'b1010: begin
                if (bus.A == bus.B) begin
                    res_d = 16'd1;
                end else begin
                    res_d = 16'd0;
                end
                flg_d = FLG_CMP;
            end
            4'b1011: begin
                if (bus.A > bus.B) begin
                    res_d = 16'd2;
                end else begin
                    res_d = 16'd0;
                end
                flg_d = FLG_CMP;
            end
            4'b1100: begin
                if (bus.A < bus.B) begin
                    res_d = 16'd3;
                end else begin
                    res_d = 16'd0;
                end
                flg_d = FLG_CMP;
            end
            4'b1101: begin res_d = {1'b0, bus.A[15:1]}; flg_d = FLG_SHIFT; end
            4'b1110: begin res_d = {bus.A[14:0], 1'b0}; flg_d = FLG_SHIFT; end
            4'b1111: begin res_d = 16'h0000;            flg_d = FLG_NONE;  end
            default: begin res_d = 16'h0000;            flg_d = FLG_NONE;  end
        endcase
    end

    // Output register; reset wins over any opcode on the same edge
    always_ff @(posedge CLK) begin
        if (RST) begin
            res_q <= 16'h0000;
            flg_q <= FLG_NONE;
        end else begin
            res_q <= res_d;
            flg_q <= flg_d;
        end
    end

    assign bus.ALU_OUT    = res_q;
    assign bus.Arith_Flag = flg_q[3];
    assign bus.Logic_Flag = flg_q[2];
    assign bus.CMP_Flag   = flg_q[1];
    assign bus.Shift_Flag = flg_q[0];
endmodule

// File: tb/tb_unsigned_16bit_alu.sv
// Scoreboard bench for unsigned_16bit_alu: directed vectors push hand-computed
// results into a queue; a monitor pops one entry per captured operation.
module tb_unsigned_16bit_alu;
    localparam logic [3:0] F_NONE  = 4'b0000;
    localparam logic [3:0] F_ARITH = 4'b1000;
    localparam logic [3:0] F_LOGIC = 4'b0100;
    localparam logic [3:0] F_CMP   = 4'b0010;
    localparam logic [3:0] F_SHIFT = 4'b0001;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic [3:0]  flg;
    } exp_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic out_valid;
    int   tests;
    int   fails;
    exp_t sb_q[$];

    unsigned_16bit_alu_if bus ();

    unsigned_16bit_alu dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tracks which edges captured a scoreboarded operation
    always @(posedge clk) out_valid <= in_valid;

    // Monitor: compare registered outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            logic [3:0] got_flg;
            exp_t e;
            got_flg = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
            tests = tests + 1;
            if (sb_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL underflow: output presented with empty scoreboard, ALU_OUT=%h", bus.ALU_OUT);
            end else begin
                e = sb_q.pop_front();
                if (bus.ALU_OUT !== e.out || got_flg !== e.flg) begin
                    fails = fails + 1;
                    $display("FAIL %s: got out=%h flags=%b, expected out=%h flags=%b",
                             e.name, bus.ALU_OUT, got_flg, e.out, e.flg);
                end
            end
        end
    end

    task automatic issue(input string name, input logic r, input logic [3:0] fun,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eo, input logic [3:0] ef);
        exp_t e;
        rst         = r;
        bus.ALU_FUN = fun;
        bus.A       = a;
        bus.B       = b;
        in_valid    = 1'b1;
        e.name = name;
        e.out  = eo;
        e.flg  = ef;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        out_valid   = 1'b0;
        in_valid    = 1'b0;
        rst         = 1'b1;
        bus.A       = 16'h0000;
        bus.B       = 16'h0000;
        bus.ALU_FUN = 4'b0000;
        @(posedge clk);
        #1;

        issue("reset_state", 1'b1, 4'b0000, 16'd10, 16'd2, 16'h0000, F_NONE);

        issue("add",  1'b0, 4'b0000, 16'd10, 16'd2, 16'd12, F_ARITH);
        issue("sub",  1'b0, 4'b0001, 16'd10, 16'd2, 16'd8,  F_ARITH);
        issue("mul",  1'b0, 4'b0010, 16'd10, 16'd2, 16'd20, F_ARITH);
        issue("div",  1'b0, 4'b0011, 16'd10, 16'd2, 16'd5,  F_ARITH);
        issue("div_trunc", 1'b0, 4'b0011, 16'd10, 16'd3, 16'd3, F_ARITH);

        issue("and",  1'b0, 4'b0100, 16'd10, 16'd2, 16'h0002, F_LOGIC);
        issue("or",   1'b0, 4'b0101, 16'd10, 16'd2, 16'h000A, F_LOGIC);
        issue("nand", 1'b0, 4'b0110, 16'd10, 16'd2, 16'hFFFD, F_LOGIC);
        issue("nor",  1'b0, 4'b0111, 16'd10, 16'd2, 16'hFFF5, F_LOGIC);
        issue("xor",  1'b0, 4'b1000, 16'd10, 16'd2, 16'h0008, F_LOGIC);
        issue("xnor", 1'b0, 4'b1001, 16'd10, 16'd2, 16'hFFF7, F_LOGIC);

        issue("eq_false", 1'b0, 4'b1010, 16'd10, 16'd2, 16'd0, F_CMP);
        issue("gt_true",  1'b0, 4'b1011, 16'd10, 16'd2, 16'd2, F_CMP);
        issue("lt_false", 1'b0, 4'b1100, 16'd10, 16'd2, 16'd0, F_CMP);
        issue("eq_true",  1'b0, 4'b1010, 16'd7,  16'd7, 16'd1, F_CMP);
        issue("gt_equal", 1'b0, 4'b1011, 16'd7,  16'd7, 16'd0, F_CMP);
        issue("lt_true",  1'b0, 4'b1100, 16'd1,  16'd9, 16'd3, F_CMP);

        issue("shr",      1'b0, 4'b1101, 16'd10,   16'd0, 16'h0005, F_SHIFT);
        issue("shl",      1'b0, 4'b1110, 16'd10,   16'd0, 16'h0014, F_SHIFT);
        issue("shl_msb",  1'b0, 4'b1110, 16'h8001, 16'd0, 16'h0002, F_SHIFT);
        issue("shr_lsb",  1'b0, 4'b1101, 16'h8001, 16'd0, 16'h4000, F_SHIFT);

        issue("nop",      1'b0, 4'b1111, 16'd10, 16'd2, 16'h0000, F_NONE);

        issue("add_wrap", 1'b0, 4'b0000, 16'hFFFF, 16'hFFFF, 16'hFFFE, F_ARITH);
        issue("mul_wrap", 1'b0, 4'b0010, 16'hFFFF, 16'hFFFF, 16'h0001, F_ARITH);
        issue("sub_wrap", 1'b0, 4'b0001, 16'd2,    16'd10,   16'hFFF8, F_ARITH);
        issue("div_zero", 1'b0, 4'b0011, 16'd10,   16'd0,    16'h0000, F_ARITH);

        issue("pre_rst_add", 1'b0, 4'b0000, 16'd100, 16'd1, 16'd101,  F_ARITH);
        issue("rst_mid_add", 1'b1, 4'b0000, 16'd10,  16'd2, 16'h0000, F_NONE);
        issue("post_rst_add", 1'b0, 4'b0000, 16'd10, 16'd2, 16'd12,   F_ARITH);
        issue("post_rst_xor", 1'b0, 4'b1000, 16'hF0F0, 16'h0FF0, 16'hFF00, F_LOGIC);

        in_valid    = 1'b0;
        bus.ALU_FUN = 4'b1111;
        repeat (3) @(posedge clk);
        #1;

        tests = tests + 1;
        if (sb_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: %0d scoreboard entries never observed, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
